// File: rtl/simon_round_controller.sv
// simon_round_controller: game FSM for the two-button Simon game.
// Draws a pattern from a free-running LFSR, plays it on two LEDs, checks the
// player's presses, and sequences external round/position counters by strobes.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   start        1-cycle pulse, begins a new game (IDLE/WIN/LOSE only)
//   btn0, btn1   debounced 1-cycle press pulses (WAIT_INPUT only)
//   round_count  external round counter (resets to 1) = current pattern length
//   pos_count    external position counter (resets to 1), 1-based pattern index
//   round_inc    increment strobe to round counter
//   round_rst    reset strobe to round counter
//   pos_inc      increment strobe to position counter
//   pos_rst      reset strobe to position counter
//   led0, led1   pattern display (element value 0 / 1)
//   win, lose    game result, held until the next start
module simon_round_controller #(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned SHOW_CYCLES    = 12500000,
  parameter int unsigned GAP_CYCLES     = 6250000,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn0,
  input  logic       btn1,
  input  logic [4:0] round_count,
  input  logic [4:0] pos_count,
  output logic       round_inc,
  output logic       round_rst,
  output logic       pos_inc,
  output logic       pos_rst,
  output logic       led0,
  output logic       led1,
  output logic       win,
  output logic       lose
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned TMR_W  = 32;
  localparam int unsigned LFSR_W = 16;
  localparam int unsigned SEQ_W  = 32;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [CNT_W-1:0]  MAX_LEN_C = CNT_W'(MAX_LEN);
  // Only the low MAX_LEN pattern bits are ever stored; the rest stay zero.
  localparam logic [SEQ_W-1:0]  SEQ_MASK  = SEQ_W'((64'd1 << MAX_LEN) - 64'd1);
  localparam logic [TMR_W-1:0]  SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0]  GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_SETTLE,
    S_WAIT_INPUT,
    S_WIN,
    S_LOSE
  } state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [SEQ_W-1:0]  seq_reg;
  logic              cur_bit;
  logic [CNT_W-1:0]  pos_idx;
  logic              seq_bit;
  logic              timed_out;

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[LFSR_W-1:1]};

  // Pattern element addressed by the 1-based position counter.
  assign pos_idx = CNT_W'(pos_count - 5'd1);
  assign seq_bit = seq_reg[pos_idx];

  assign timed_out = (TIMEOUT_CYCLES != 0) && (timer == TO_LAST);

  // Game FSM with registered strobes/LEDs; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      lfsr      <= LFSR_SEED;
      seq_reg   <= '0;
      cur_bit   <= 1'b0;
      round_inc <= 1'b0;
      round_rst <= 1'b1;
      pos_inc   <= 1'b0;
      pos_rst   <= 1'b1;
      led0      <= 1'b0;
      led1      <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      lfsr      <= lfsr_next;
      timer     <= timer + 32'd1;
      round_inc <= 1'b0;
      round_rst <= 1'b0;
      pos_inc   <= 1'b0;
      pos_rst   <= 1'b0;
      led0      <= 1'b0;
      led1      <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;

      case (state)
        S_IDLE: begin
          // Counters are held in reset while idle and through CLEAR.
          round_rst <= 1'b1;
          pos_rst   <= 1'b1;
          if (start) begin
            state <= S_CLEAR;
            timer <= '0;
          end
        end

        S_CLEAR: begin
          // Two consecutive LFSR states cover patterns longer than 16.
          seq_reg <= {lfsr_next, lfsr} & SEQ_MASK;
          state   <= S_LOAD;
          timer   <= '0;
        end

        S_LOAD: begin
          cur_bit <= seq_bit;
          led0    <= ~seq_bit;
          led1    <= seq_bit;
          state   <= S_SHOW_ON;
          timer   <= '0;
        end

        S_SHOW_ON: begin
          if (timer == SHOW_LAST) begin
            state <= S_SHOW_OFF;
            timer <= '0;
          end else begin
            led0 <= ~cur_bit;
            led1 <= cur_bit;
          end
        end

        S_SHOW_OFF: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            if (pos_count < round_count) begin
              pos_inc <= 1'b1;
              state   <= S_LOAD;
            end else begin
              pos_rst <= 1'b1;
              state   <= S_SETTLE;
            end
          end
        end

        S_SETTLE: begin
          state <= S_WAIT_INPUT;
          timer <= '0;
        end

        S_WAIT_INPUT: begin
          if (btn0 && btn1) begin
            lose  <= 1'b1;
            state <= S_LOSE;
            timer <= '0;
          end else if (btn0 || btn1) begin
            timer <= '0;
            if (btn1 != seq_bit) begin
              lose  <= 1'b1;
              state <= S_LOSE;
            end else if (pos_count < round_count) begin
              pos_inc <= 1'b1;
              state   <= S_SETTLE;
            end else if (round_count == MAX_LEN_C) begin
              win   <= 1'b1;
              state <= S_WIN;
            end else begin
              round_inc <= 1'b1;
              pos_rst   <= 1'b1;
              state     <= S_LOAD;
            end
          end else if (timed_out) begin
            lose  <= 1'b1;
            state <= S_LOSE;
            timer <= '0;
          end
        end

        S_WIN, S_LOSE: begin
          // Counters are left alone so round_count keeps the final score.
          if (start) begin
            round_rst <= 1'b1;
            pos_rst   <= 1'b1;
            state     <= S_CLEAR;
            timer     <= '0;
          end else begin
            win  <= (state == S_WIN);
            lose <= (state == S_LOSE);
          end
        end

        default: begin
          state <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_round_controller.sv
// Testbench for simon_round_controller: behavioural counters on the strobes,
// an expected-trace game model, and per-cycle output comparison.
module tb_simon_round_controller;

  localparam int unsigned MAX_LEN = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       btn0 = 1'b0;
  logic       btn1 = 1'b0;
  logic [4:0] round_cnt = 5'd1;
  logic [4:0] pos_cnt = 5'd1;
  logic       round_inc, round_rst, pos_inc, pos_rst;
  logic       led0, led1, win, lose;

  simon_round_controller #(
    .MAX_LEN(MAX_LEN),
    .SHOW_CYCLES(4),
    .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .btn0(btn0),
    .btn1(btn1),
    .round_count(round_cnt),
    .pos_count(pos_cnt),
    .round_inc(round_inc),
    .round_rst(round_rst),
    .pos_inc(pos_inc),
    .pos_rst(pos_rst),
    .led0(led0),
    .led1(led1),
    .win(win),
    .lose(lose)
  );

  always #5 clk = ~clk;

  // External counters update on the falling edge.
  always @(negedge clk) begin
    if (round_rst) round_cnt <= 5'd1;
    else if (round_inc) round_cnt <= round_cnt + 5'd1;
    if (pos_rst) pos_cnt <= 5'd1;
    else if (pos_inc) pos_cnt <= pos_cnt + 5'd1;
  end

  // Output vector: {round_inc, round_rst, pos_inc, pos_rst, led0, led1, win, lose}
  logic [7:0] dut_vec;
  assign dut_vec = {round_inc, round_rst, pos_inc, pos_rst, led0, led1, win, lose};

  localparam logic [7:0] V_IDLE  = 8'b0101_0000;
  localparam logic [7:0] V_ZERO  = 8'b0000_0000;
  localparam logic [7:0] V_RNEXT = 8'b1001_0000;
  localparam logic [7:0] V_PINC  = 8'b0010_0000;
  localparam logic [7:0] V_PRST  = 8'b0001_0000;
  localparam logic [7:0] V_WIN   = 8'b0000_0010;
  localparam logic [7:0] V_LOSE  = 8'b0000_0001;

  function automatic logic [7:0] v_led(input logic b);
    return {4'b0000, ~b, b, 2'b00};
  endfunction

  // Pattern source as the polynomial defines it: feedback is the parity of
  // the tapped bits, shifted in at the top.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = ^(s & 16'h002D);
    return {fb, s[15:1]};
  endfunction

  logic [15:0] m_lfsr = 16'hACE1;
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else m_lfsr <= lfsr_step(m_lfsr);
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] pat;
  int m_round;
  int m_pos;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Advance one clock, compare all outputs, then drop any pulse inputs.
  task automatic tick(input logic [7:0] exp, input string name);
    @(posedge clk);
    #1;
    cyc++;
    n_chk++;
    if (dut_vec !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %b expected %b", name, cyc, dut_vec, exp);
    end
    start = 1'b0;
    btn0  = 1'b0;
    btn1  = 1'b0;
  endtask

  // Expected trace for showing the whole current round, ending in WAIT_INPUT.
  task automatic show_round(input logic [7:0] load_vec);
    for (int i = 0; i < m_round; i++) begin
      tick((i == 0) ? load_vec : V_PINC, "load");
      for (int k = 0; k < 4; k++) tick(v_led(pat[i]), "show_on");
      for (int k = 0; k < 2; k++) tick(V_ZERO, "show_off");
    end
    tick(V_PRST, "settle");
    tick(V_ZERO, "wait_entry");
    check("round_count", 16'(round_cnt), 16'(m_round));
    check("pos_count", 16'(pos_cnt), 16'd1);
    m_pos = 1;
  endtask

  // Start pulse from IDLE/WIN/LOSE through the first round's display.
  task automatic new_game;
    start = 1'b1;
    tick(V_IDLE, "clear");
    pat     = m_lfsr;
    m_round = 1;
    show_round(V_ZERO);
  endtask

  // One press; the expected reaction follows from the model's round/pos.
  task automatic press(input logic b);
    if (b) btn1 = 1'b1;
    else btn0 = 1'b1;
    if (b != pat[m_pos-1]) begin
      tick(V_LOSE, "press_wrong");
    end else if (m_pos < m_round) begin
      tick(V_PINC, "press_next");
      m_pos++;
      tick(V_ZERO, "wait_next");
      check("pos_after_inc", 16'(pos_cnt), 16'(m_pos));
    end else if (m_round == MAX_LEN) begin
      tick(V_WIN, "press_win");
    end else begin
      m_round++;
      show_round(V_RNEXT);
    end
  endtask

  initial begin
    // Pin the model's LFSR against hand-derived states.
    check("lfsr_step1", lfsr_step(16'hACE1), 16'h5670);
    check("lfsr_step2", lfsr_step(16'h5670), 16'hAB38);

    for (int i = 0; i < 3; i++) tick(V_IDLE, "reset");
    check("reset_round", 16'(round_cnt), 16'd1);
    check("reset_pos", 16'(pos_cnt), 16'd1);

    // Game 1: start on the first edge out of reset; play through to WIN.
    reset = 1'b0;
    start = 1'b1;
    tick(V_IDLE, "clear1");
    pat = m_lfsr;
    check("pattern_state", pat, 16'h5670);
    m_round = 1;
    show_round(V_ZERO);
    start = 1'b1;
    tick(V_ZERO, "start_ignored");
    press(pat[0]);
    press(pat[0]);
    press(pat[1]);
    press(pat[0]);
    press(pat[1]);
    press(pat[2]);
    btn0 = 1'b1;
    tick(V_WIN, "win_btn0");
    btn1 = 1'b1;
    tick(V_WIN, "win_btn1");
    tick(V_WIN, "win_hold");
    check("win_score", 16'(round_cnt), 16'd3);

    // Game 2: wrong button at position 2 of round 2.
    new_game();
    press(pat[0]);
    press(pat[0]);
    press(~pat[1]);
    btn0 = 1'b1;
    tick(V_LOSE, "lose_btn0");
    btn1 = 1'b1;
    tick(V_LOSE, "lose_btn1");
    check("lose_score", 16'(round_cnt), 16'd2);
    check("lose_pos", 16'(pos_cnt), 16'd2);

    // Game 3: both buttons in the same cycle.
    new_game();
    btn0 = 1'b1;
    btn1 = 1'b1;
    tick(V_LOSE, "both_buttons");
    tick(V_LOSE, "both_hold");

    // Game 4: no press; loss lands 10 cycles after entering WAIT_INPUT.
    new_game();
    for (int i = 0; i < 9; i++) tick(V_ZERO, "timeout_wait");
    tick(V_LOSE, "timeout_lose");
    check("timeout_score", 16'(round_cnt), 16'd1);

    // Game 5: reset in the middle of SHOW_ON.
    start = 1'b1;
    tick(V_IDLE, "clear5");
    pat = m_lfsr;
    tick(V_ZERO, "load5");
    tick(v_led(pat[0]), "show5a");
    tick(v_led(pat[0]), "show5b");
    reset = 1'b1;
    tick(V_IDLE, "reset_mid_show");
    reset = 1'b0;
    tick(V_IDLE, "idle_after_reset");
    tick(V_IDLE, "idle_hold");
    check("reset_round5", 16'(round_cnt), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_round_controller.md
Name: simon_round_controller

Overview:
- Game FSM for the two-button Simon game.
- Generates the pattern, plays it on two LEDs and checks player presses.
- Sequences the external round counter and position counter using their increment and reset strobes.
- Sits between the debounced button pulses, the two counter instances and the LED/status outputs.

Parameters:
- MAX_LEN, 16, rounds needed to win; legal range 1..31 (5-bit counters).
- SHOW_CYCLES, 12500000, clk cycles an LED stays lit per pattern element.
- GAP_CYCLES, 6250000, dark cycles after each shown element.
- TIMEOUT_CYCLES, 0, max idle cycles in WAIT_INPUT before loss; 0 disables.

Ports:
- clk  in  1  system clock; FSM acts on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a new game.
- btn0  in  1  debounced single-cycle press pulse, button 0.
- btn1  in  1  debounced single-cycle press pulse, button 1.
- round_count  in  5  round counter value; resets to 1; equals current pattern length.
- pos_count  in  5  position counter value; resets to 1; 1-based index into pattern.
- round_inc  out  1  increment strobe to round counter.
- round_rst  out  1  reset strobe to round counter.
- pos_inc  out  1  increment strobe to position counter.
- pos_rst  out  1  reset strobe to position counter.
- led0  out  1  pattern display, element 0.
- led1  out  1  pattern display, element 1.
- win  out  1  held high in WIN.
- lose  out  1  held high in LOSE.

Behaviour:
- Outputs: all registered.
- On reset: state IDLE; round_rst=pos_rst=1; all other outputs 0; timer 0; LFSR seed 16'hACE1.
- Pattern source LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Advances every cycle, including during reset-release and IDLE. Never all-zero.
- Counter handshake:
  - Strobes are 1-cycle pulses.
  - Counter values are consumed no earlier than the cycle after the strobe (counters update on the opposite clock edge).
  - inc and rst to the same counter are never asserted together.
- IDLE: round_rst=pos_rst held 1. On start -> CLEAR.
- CLEAR (1 cycle):
  - seq_reg[MAX_LEN-1:0] <= LFSR[MAX_LEN-1:0]; MAX_LEN>16 uses two consecutive LFSR states.
  - round_rst=pos_rst=1; win=lose=0.
  - -> LOAD.
- LOAD (1 cycle): bit b=seq_reg[pos_count-1] latched; -> SHOW_ON.
- SHOW_ON: led0=~b, led1=b for exactly SHOW_CYCLES cycles; -> SHOW_OFF.
- SHOW_OFF: both LEDs 0 for GAP_CYCLES cycles. At the last cycle:
  - pos_count<round_count: pulse pos_inc; -> LOAD.
  - pos_count==round_count: pulse pos_rst; -> SETTLE.
- SETTLE (1 cycle): buttons ignored; timer cleared; -> WAIT_INPUT.
- WAIT_INPUT: LEDs 0; compare e=seq_reg[pos_count-1].
  - btn0 xor btn1, pressed bit == e, pos_count<round_count: pulse pos_inc; -> SETTLE.
  - Correct, pos_count==round_count, round_count==MAX_LEN: -> WIN.
  - Correct, pos_count==round_count, round_count<MAX_LEN: pulse round_inc and pos_rst in the same cycle; -> LOAD.
  - Wrong bit, or btn0 and btn1 both high in the same cycle: -> LOSE.
  - No press: stay; timer increments. TIMEOUT_CYCLES>0 and timer reaches TIMEOUT_CYCLES-1 -> LOSE.
- WIN / LOSE:
  - win or lose held 1; LEDs 0.
  - Counters untouched, so round_count keeps the final score.
  - start -> CLEAR.
- start outside IDLE/WIN/LOSE: ignored.
- Buttons outside WAIT_INPUT: ignored.
- reset at any time, mid-show or mid-input: returns to IDLE next edge with reset values, regardless of other inputs.
- Timer: 32-bit; cleared on every state change.

Test Plan:
Bench instantiates two behavioural 5-bit counters (reset to 1) wired to the strobes. Parameters: MAX_LEN=3, SHOW_CYCLES=4, GAP_CYCLES=2.
- Reset then start -> CLEAR 1 cycle; round=pos=1; exactly one LED high for 4 cycles, dark for 2; pos_rst pulse; enters WAIT_INPUT.
- Round 1 correct press -> round_inc+pos_rst same cycle; round_count=2; two elements shown, each 4 on / 2 off; pos_inc pulsed once between them.
- Correct presses through round 3 -> win=1 held; round_count=3; further button pulses cause no strobes.
- Wrong button on pos 2 of round 2 -> lose=1; round_count stays 2; no strobes afterwards.
- btn0 and btn1 both high in the same cycle in WAIT_INPUT -> lose=1.
- TIMEOUT_CYCLES=10, no press -> lose=1 exactly 10 cycles after entering WAIT_INPUT. Reset asserted mid-SHOW_ON -> IDLE, LEDs 0, round_rst=pos_rst=1 on the next edge.
